alu: RTL and testbench
======================

Name: alu

Overview:
- 16-bit combinational ALU datapath followed by an output register. Used as the arithmetic/logic unit of the CPU datapath.
- Seven control bits configure a single carry-chain adder into add, sub, inc, dec, negate, not, xor, or and and.
- Result and carry-out are registered, giving one cycle of latency.

Parameters:
- WIDTH, 16, datapath width in bits. All test values below assume 16.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry into bit 0
- nb  input  1  invert B, applied after zb
- ic  input  1  inhibit carry; all carries, including ci, are forced to 0
- zb  input  1  zero B, applied before nb
- na  input  1  invert A
- xo  input  1  OR the generate term a'&b' into each result bit
- no  input  1  invert result
- sh  input  2  shift select; used only with ALU_SHIFT_EN, ignored otherwise
- out  output  WIDTH  registered result
- co  output  1  registered carry-out

Behaviour:
- Operand conditioning:
  - a' = na ? ~a : a
  - b0 = zb ? 0 : b
  - b' = nb ? ~b0 : b0
- Per bit i: p = a'[i]^b'[i], g = a'[i]&b'[i].
- Carry chain:
  - c[0] = ic ? 0 : ci
  - c[i+1] = ic ? 0 : (g | (p & c[i]))
- Bit result: r[i] = (p ^ c[i]) | (xo & g).
- Final result: res = no ? ~r : r. Raw carry: cr = c[WIDTH]; cr is not affected by no and is 0 whenever ic=1.
- Resulting operations (ci,nb,ic,zb,na,xo,no):
  - add 0000000 (a+b)
  - sub 1100000 (a-b)
  - xor 0010000
  - inc 1001000
  - dec 0101000
  - not 0111000 (~a)
  - neg 1001100 (-a)
  - or 0010010
  - and 0110111
- Arithmetic is modulo 2^WIDTH. Wrap-around is silent; co reports the unsigned carry (0xFFFE+2 gives out=0, co=1).
- Register: on each rising clk edge:
  - if rst=1: out <= 0, co <= 0
  - else: out <= res, co <= cr
- Latency is exactly 1 cycle. There is no enable and no handshake; a new operation may be accepted every cycle.
- rst asserted mid-stream takes priority; the register clears and the in-flight result is discarded. The first result after rst deasserts reflects the inputs present at that edge.
- Unlisted combinations of control bits are legal and follow the equations above.

Optional Feature:
- Macro ALU_SHIFT_EN.
- When defined, sh selects a shifter on a' that bypasses the adder:
  - 00: adder path as above
  - 01: shl1 (a'<<1, cr = a'[WIDTH-1])
  - 10: lsr1 (a'>>1 with 0 fill, cr = a'[0])
  - 11: asr1 (a'>>1 with sign fill, cr = a'[0])
- In shift modes, no still inverts the result. All other controls except na are ignored.
- When not defined, sh is ignored and the adder path always applies.

Test Plan:
- Reset: rst=1 for 1 cycle with any inputs -> out=0, co=0. Deassert, apply add a=9, b=8 -> out=17 one cycle later.
- Add/wrap: a=7,b=-6 -> 1; a=7,b=-9 -> 0xFFFE (-2); a=65534,b=1 -> 65535, co=0; a=65534,b=2 -> 0, co=1.
- Sub/inc/dec: sub a=10,b=4 -> 6; inc a=16 -> 17; dec a=16 -> 15. Each checked one clock after the inputs are applied.
- Logic: xor 10,9 -> 3; or 10,9 -> 11; and 10,9 -> 8; not 16 -> 65519; neg 16 -> 0xFFF0 (-16). co=0 for xor, or, and and.
- Back-to-back: change the operation every cycle over 5 cycles -> each result appears exactly one cycle after its inputs. Assert rst in cycle 3 -> out=0 in cycle 4.
- ALU_SHIFT_EN:
  - sh=01, a=0x8001 -> out=0x0002, co=1
  - sh=11, a=0x8002 -> out=0xC001, co=0
  - sh=10, a=0x8002 -> out=0x4001
  - Without the macro, sh=01 gives the plain add result.

Source files
------------

// File: rtl/alu.sv
// Configurable 16-bit carry-chain ALU (add/sub/inc/dec/neg/not/xor/or/and) with a registered result and carry-out.
// Latency is 1 cycle; it takes a new op every cycle and has no backpressure. The optional shifter is enabled by `define ALU_SHIFT_EN.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             nb,
  input  logic             ic,
  input  logic             zb,
  input  logic             na,
  input  logic             xo,
  input  logic             no,
  input  logic [1:0]       sh,
  output logic [WIDTH-1:0] out,
  output logic             co
);

  logic [WIDTH-1:0] a_c, b_z, b_c, p, g, r, r_sel;
  logic [WIDTH:0]   c;
  logic             cr;
  logic [WIDTH-1:0] out_d, out_q;
  logic             co_d, co_q;

`ifndef ALU_SHIFT_EN
  logic unused_sh;
  assign unused_sh = ^sh;
`endif

  always_comb begin
    a_c = na ? ~a : a;
    b_z = zb ? '0 : b;
    b_c = nb ? ~b_z : b_z;
    p   = a_c ^ b_c;
    g   = a_c & b_c;
    c   = '0;
    c[0] = ic ? 1'b0 : ci;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = ic ? 1'b0 : (g[i] | (p[i] & c[i]));
    end
    // xo lets the generate term through, turning xor into or.
    r     = (p ^ c[WIDTH-1:0]) | ({WIDTH{xo}} & g);
    r_sel = r;
    cr    = c[WIDTH];
`ifdef ALU_SHIFT_EN
    case (sh)
      2'b01: begin
        r_sel = {a_c[WIDTH-2:0], 1'b0};
        cr    = a_c[WIDTH-1];
      end
      2'b10: begin
        r_sel = {1'b0, a_c[WIDTH-1:1]};
        cr    = a_c[0];
      end
      2'b11: begin
        r_sel = {a_c[WIDTH-1], a_c[WIDTH-1:1]};
        cr    = a_c[0];
      end
      default: ;
    endcase
`endif
    out_d = no ? ~r_sel : r_sel;
    co_d  = cr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      co_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      co_q  <= co_d;
    end
  end

  assign out = out_q;
  assign co  = co_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results, a monitor pops and compares one cycle later.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        ci = 0, nb = 0, ic = 0, zb = 0, na = 0, xo = 0, no = 0;
  logic [1:0]  sh = '0;
  logic [15:0] out;
  logic        co;

  typedef struct {
    string       name;
    logic [15:0] eout;
    logic        eco;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [6:0] OP_ADD = 7'b0000000;
  localparam logic [6:0] OP_SUB = 7'b1100000;
  localparam logic [6:0] OP_XOR = 7'b0010000;
  localparam logic [6:0] OP_INC = 7'b1001000;
  localparam logic [6:0] OP_DEC = 7'b0101000;
  localparam logic [6:0] OP_NOT = 7'b0111000;
  localparam logic [6:0] OP_NEG = 7'b1001100;
  localparam logic [6:0] OP_OR  = 7'b0010010;
  localparam logic [6:0] OP_AND = 7'b0110111;

  alu #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .ci(ci), .nb(nb), .ic(ic), .zb(zb),
    .na(na), .xo(xo), .no(no), .sh(sh), .out(out), .co(co)
  );

  always #5 clk = ~clk;

  task automatic apply(input string nm, input logic r, input logic [6:0] ctl,
                       input logic [15:0] aa, input logic [15:0] bb, input logic [1:0] s,
                       input logic [15:0] eo, input logic ec);
    exp_t e;
    @(negedge clk);
    rst = r;
    {ci, nb, ic, zb, na, xo, no} = ctl;
    a = aa;
    b = bb;
    sh = s;
    e.name = nm;
    e.eout = eo;
    e.eco  = ec;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (out !== e.eout) begin
          errors++;
          $display("FAIL %s out: got %h expected %h", e.name, out, e.eout);
        end
        checks++;
        if (co !== e.eco) begin
          errors++;
          $display("FAIL %s co: got %b expected %b", e.name, co, e.eco);
        end
      end
    end
  end

  initial begin : stim
    int budget;
    apply("reset",     1'b1, OP_ADD, 16'd1234, 16'd1,  2'b00, 16'h0000, 1'b0);
    apply("add_9_8",   1'b0, OP_ADD, 16'd9,    16'd8,  2'b00, 16'd17,   1'b0);
    apply("add_7_m6",  1'b0, OP_ADD, 16'd7,    16'hFFFA, 2'b00, 16'd1,  1'b1);
    apply("add_7_m9",  1'b0, OP_ADD, 16'd7,    16'hFFF7, 2'b00, 16'hFFFE, 1'b0);
    apply("add_fffe_1",1'b0, OP_ADD, 16'hFFFE, 16'd1,  2'b00, 16'hFFFF, 1'b0);
    apply("add_fffe_2",1'b0, OP_ADD, 16'hFFFE, 16'd2,  2'b00, 16'h0000, 1'b1);
    apply("sub_10_4",  1'b0, OP_SUB, 16'd10,   16'd4,  2'b00, 16'd6,    1'b1);
    apply("inc_16",    1'b0, OP_INC, 16'd16,   16'd77, 2'b00, 16'd17,   1'b0);
    apply("dec_16",    1'b0, OP_DEC, 16'd16,   16'd77, 2'b00, 16'd15,   1'b1);
    apply("xor_10_9",  1'b0, OP_XOR, 16'd10,   16'd9,  2'b00, 16'd3,    1'b0);
    apply("or_10_9",   1'b0, OP_OR,  16'd10,   16'd9,  2'b00, 16'd11,   1'b0);
    apply("and_10_9",  1'b0, OP_AND, 16'd10,   16'd9,  2'b00, 16'd8,    1'b0);
    apply("not_16",    1'b0, OP_NOT, 16'd16,   16'd5,  2'b00, 16'd65519, 1'b0);
    apply("neg_16",    1'b0, OP_NEG, 16'd16,   16'd5,  2'b00, 16'hFFF0, 1'b0);
    apply("neg_0",     1'b0, OP_NEG, 16'd0,    16'd5,  2'b00, 16'h0000, 1'b1);
    // Back-to-back stream with reset landing on the third cycle.
    apply("b2b_add",   1'b0, OP_ADD, 16'd3,    16'd4,  2'b00, 16'd7,    1'b0);
    apply("b2b_sub",   1'b0, OP_SUB, 16'd9,    16'd2,  2'b00, 16'd7,    1'b1);
    apply("b2b_rst",   1'b1, OP_XOR, 16'hAAAA, 16'h5555, 2'b00, 16'h0000, 1'b0);
    apply("b2b_inc",   1'b0, OP_INC, 16'd5,    16'd0,  2'b00, 16'd6,    1'b0);
    apply("b2b_and",   1'b0, OP_AND, 16'd12,   16'd10, 2'b00, 16'd8,    1'b0);
`ifdef ALU_SHIFT_EN
    apply("shl1",      1'b0, OP_ADD, 16'h8001, 16'd3,  2'b01, 16'h0002, 1'b1);
    apply("asr1",      1'b0, OP_ADD, 16'h8002, 16'd3,  2'b11, 16'hC001, 1'b0);
    apply("lsr1",      1'b0, OP_ADD, 16'h8002, 16'd3,  2'b10, 16'h4001, 1'b0);
`else
    apply("sh_ignored",1'b0, OP_ADD, 16'd9,    16'd8,  2'b01, 16'd17,   1'b0);
`endif
    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
